imem_boot_loader: RTL
=====================

Name: imem_boot_loader

Overview:
- Front-end block upstream of the RV32I 2-stage core.
- Receives a byte stream from a host link (UART RX or JTAG shim) and assembles little-endian 32-bit instruction words.
- Drives the core's instruction-memory write port (imem_wr_data / imem_wr_en) and holds the core in reset until a complete, checksum-verified image is loaded.

Parameters:
- MAX_WORDS, 1024, largest accepted image in 32-bit words; the header count must not exceed this.
- TIMEOUT_CYCLES, 100000, maximum idle cycles between bytes once a load has started; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; (re)arms the loader from DONE or ERR
- byte_in  input  8  incoming stream byte
- byte_valid  input  1  byte_in valid
- byte_ready  output  1  loader accepts a byte this cycle
- imem_wr_data  output  32  assembled instruction word
- imem_wr_addr  output  32  byte address of imem_wr_data (word index × 4)
- imem_wr_en  output  1  one-cycle write strobe
- cpu_rst_n  output  1  active-low reset to cpu_top; low until DONE
- load_done  output  1  image loaded and checksum matched
- load_err  output  1  error latched
- err_code  output  2  0 none, 1 bad checksum, 2 count > MAX_WORDS, 3 timeout

Behaviour:
- Reset (asynchronous, active-low) forces:
  - state = HDR0
  - byte_ready = 1
  - imem_wr_en = 0; imem_wr_data = 0; imem_wr_addr = 0
  - cpu_rst_n = 0; load_done = 0; load_err = 0; err_code = 0
  - all counters, checksum and timer = 0
- Handshake: a byte transfers on a rising edge when byte_valid && byte_ready. byte_ready = 1 in HDR0, HDR1, PAYLOAD and CKSUM; 0 in DONE and ERR.
- Frame format:
  - count_lo, count_hi: N, a 16-bit little-endian word count
  - 4×N payload bytes; each word is little-endian (first byte = bits [7:0])
  - one checksum byte equal to the XOR of all payload bytes only (header not included)
- State transitions:
  - HDR0: accept byte -> store count[7:0] -> HDR1.
  - HDR1: accept byte -> store count[15:8]. If N > MAX_WORDS -> ERR (code 2). If N = 0 -> CKSUM. Otherwise -> PAYLOAD.
  - PAYLOAD: each accepted byte shifts into the word assembler at lane byte_idx (0..3) and XORs into the running checksum.
    - On the 4th byte: imem_wr_en = 1 on the next cycle, for exactly one cycle, with imem_wr_data = assembled word and imem_wr_addr = word_idx × 4. word_idx then increments.
    - After word N-1 is written -> CKSUM.
    - Write latency: 1 cycle from acceptance of the 4th byte.
  - CKSUM: accept byte. Match -> DONE. Mismatch -> ERR (code 1).
  - DONE: load_done = 1; cpu_rst_n = 1 starting the cycle after entry. Incoming bytes are ignored (byte_ready = 0).
  - ERR: load_err = 1; err_code held; cpu_rst_n stays 0.
- start pulse:
  - In DONE or ERR: return to HDR0, clear flags/counters/checksum, drive cpu_rst_n = 0.
  - In any other state: ignored.
- Timeout:
  - The timer runs only in HDR1, PAYLOAD and CKSUM.
  - It clears on every accepted byte.
  - Reaching TIMEOUT_CYCLES -> ERR (code 3).
  - HDR0 never times out.
- Simultaneous events: if a byte is accepted in the same cycle the timer would expire, the byte wins.
- Reset mid-load: aborts immediately. No further writes. The partially written imem contents are don't-care; the core stays in reset until a full reload completes.
- imem_wr_en never asserts outside PAYLOAD completion.
- word_idx width is clog2(MAX_WORDS)+1. The address wraps only when N exceeds MAX_WORDS, and that case is rejected first.

Test Plan:
- Normal load: N=2, words 0x00500093 and 0x00A00113, checksum = XOR of the 8 payload bytes. Expect:
  - two imem_wr_en pulses: addr 0x0 data 0x00500093, then addr 0x4 data 0x00A00113
  - load_done = 1
  - cpu_rst_n rises 1 cycle after the checksum byte
- Bad checksum: same frame with checksum XOR 0x01 -> load_err = 1, err_code = 1, cpu_rst_n stays 0. A start pulse followed by the correct frame -> load_done = 1.
- Oversize: header N = MAX_WORDS+1 -> ERR, err_code = 2, zero write pulses.
- Empty image: N = 0, checksum 0x00 -> DONE with no writes. Checksum 0x5A instead -> err_code = 1.
- Timeout: with TIMEOUT_CYCLES = 16, stall after 2 payload bytes -> ERR with err_code = 3 on cycle 16. Repeat, but deliver a byte on cycle 16 -> no error.
- Backpressure/async reset: toggle byte_valid randomly across a 4-word load -> correct words written. Assert rst_n low mid-payload -> all outputs return to their reset values immediately without waiting for clk.

Source files
------------

// File: rtl/imem_boot_loader.sv
// Boot loader: assembles a length-prefixed, XOR-checksummed byte stream into
// 32-bit instruction-memory writes and holds the core in reset until verified.
module imem_boot_loader #(
    parameter int MAX_WORDS      = 1024,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] imem_wr_data,
    output logic [31:0] imem_wr_addr,
    output logic        imem_wr_en,
    output logic        cpu_rst_n,
    output logic        load_done,
    output logic        load_err,
    output logic [1:0]  err_code
);

    localparam int WIW    = $clog2(MAX_WORDS) + 1;
    localparam int TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int TMAX_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [TW-1:0] TMAX = TW'(TMAX_I);

    typedef enum logic [2:0] {
        HDR0,
        HDR1,
        PAYLOAD,
        CKSUM,
        DONE,
        ERR
    } state_t;

    state_t         state, state_d;
    logic [15:0]    count, count_d;
    logic [1:0]     byte_idx, byte_idx_d;
    logic [WIW-1:0] word_idx, word_idx_d;
    logic [23:0]    word_buf, word_buf_d;
    logic [7:0]     cksum, cksum_d;
    logic [TW-1:0]  timer, timer_d;
    logic           wr_en_d;
    logic [31:0]    wr_data_d;
    logic [31:0]    wr_addr_d;
    logic           cpu_rst_n_d;
    logic           load_done_d;
    logic           load_err_d;
    logic [1:0]     err_code_d;

    logic           accept;
    logic           timed;
    logic           expire;
    logic [15:0]    hdr_n;
    logic [31:0]    word_full;

    assign byte_ready = (state != DONE) && (state != ERR);
    assign accept     = byte_valid && byte_ready;
    assign timed      = (state == HDR1) || (state == PAYLOAD) || (state == CKSUM);
    // An accepted byte in the expiry cycle takes priority over the timeout.
    assign expire     = timed && !accept && (TIMEOUT_CYCLES != 0) && (timer == TMAX);
    assign hdr_n      = {byte_in, count[7:0]};
    assign word_full  = {byte_in, word_buf};

    always_comb begin
        state_d     = state;
        count_d     = count;
        byte_idx_d  = byte_idx;
        word_idx_d  = word_idx;
        word_buf_d  = word_buf;
        cksum_d     = cksum;
        timer_d     = '0;
        wr_en_d     = 1'b0;
        wr_data_d   = imem_wr_data;
        wr_addr_d   = imem_wr_addr;
        cpu_rst_n_d = (state == DONE) && !start;
        load_done_d = load_done;
        load_err_d  = load_err;
        err_code_d  = err_code;

        if (timed && !accept && (TIMEOUT_CYCLES != 0)) begin
            timer_d = timer + TW'(1);
        end

        case (state)
            HDR0: begin
                if (accept) begin
                    count_d = {8'h00, byte_in};
                    state_d = HDR1;
                end
            end
            HDR1: begin
                if (accept) begin
                    count_d = hdr_n;
                    if (int'(hdr_n) > MAX_WORDS) begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                        err_code_d = 2'd2;
                    end else if (hdr_n == 16'h0000) begin
                        state_d = CKSUM;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    cksum_d    = cksum ^ byte_in;
                    byte_idx_d = byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_buf_d[7:0]   = byte_in;
                        2'd1: word_buf_d[15:8]  = byte_in;
                        2'd2: word_buf_d[23:16] = byte_in;
                        default: begin
                            wr_en_d    = 1'b1;
                            wr_data_d  = word_full;
                            wr_addr_d  = 32'(word_idx) << 2;
                            word_idx_d = word_idx + WIW'(1);
                            if (32'(word_idx) + 32'd1 == {16'h0000, count}) begin
                                state_d = CKSUM;
                            end
                        end
                    endcase
                end
            end
            CKSUM: begin
                if (accept) begin
                    if (byte_in == cksum) begin
                        state_d     = DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d    = ERR;
                        load_err_d = 1'b1;
                        err_code_d = 2'd1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d     = HDR0;
                    count_d     = '0;
                    byte_idx_d  = '0;
                    word_idx_d  = '0;
                    word_buf_d  = '0;
                    cksum_d     = '0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                    err_code_d  = 2'd0;
                end
            end
        endcase

        if (expire) begin
            state_d    = ERR;
            load_err_d = 1'b1;
            err_code_d = 2'd3;
            timer_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HDR0;
            count        <= '0;
            byte_idx     <= '0;
            word_idx     <= '0;
            word_buf     <= '0;
            cksum        <= '0;
            timer        <= '0;
            imem_wr_en   <= 1'b0;
            imem_wr_data <= '0;
            imem_wr_addr <= '0;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            err_code     <= 2'd0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            byte_idx     <= byte_idx_d;
            word_idx     <= word_idx_d;
            word_buf     <= word_buf_d;
            cksum        <= cksum_d;
            timer        <= timer_d;
            imem_wr_en   <= wr_en_d;
            imem_wr_data <= wr_data_d;
            imem_wr_addr <= wr_addr_d;
            cpu_rst_n    <= cpu_rst_n_d;
            load_done    <= load_done_d;
            load_err     <= load_err_d;
            err_code     <= err_code_d;
        end
    end

endmodule
